// File: rtl/control_sequencer.sv
// Hardwired control unit for the single-bus datapath: fetch (T0-T2), decode,
// and register-register ALU execute (T3-T5), with HALT and illegal-op traps.
module control_sequencer #(
  parameter logic [4:0]  ALU_OP_MAX = 5'd11,
  parameter logic [4:0]  HALT_OP    = 5'b11011,
  parameter int unsigned COUNT_W    = 16
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               run,
  input  logic               mem_ready,
  input  logic [31:0]        ir_data,
  output logic               pc_out,
  output logic               mdr_out,
  output logic               zlo_out,
  output logic               mar_enable,
  output logic               pc_enable,
  output logic               pc_increment,
  output logic               read,
  output logic               mdr_enable,
  output logic               ir_enable,
  output logic               y_enable,
  output logic               z_enable,
  output logic [15:0]        r_out,
  output logic [15:0]        r_enable,
  output logic [4:0]         op_code,
  output logic               busy,
  output logic               halted,
  output logic               error,
  output logic [COUNT_W-1:0] instr_count
);

  localparam logic [3:0] IDLE   = 4'd0;
  localparam logic [3:0] T0     = 4'd1;
  localparam logic [3:0] T1     = 4'd2;
  localparam logic [3:0] T2     = 4'd3;
  localparam logic [3:0] DEC    = 4'd4;
  localparam logic [3:0] T3     = 4'd5;
  localparam logic [3:0] T4     = 4'd6;
  localparam logic [3:0] T5     = 4'd7;
  localparam logic [3:0] HALTED = 4'd8;
  localparam logic [3:0] ERROR  = 4'd9;

  logic [3:0] state;
  logic [3:0] state_next;
  logic [4:0] op;
  logic [3:0] ra;
  logic [3:0] rb;
  logic [3:0] rc;
  logic       unused_ir;

  assign op        = ir_data[31:27];
  assign ra        = ir_data[26:23];
  assign rb        = ir_data[22:19];
  assign rc        = ir_data[18:15];
  assign unused_ir = ^ir_data[14:0];

  always_ff @(posedge clk) begin
    if (!clr) begin
      state       <= IDLE;
      instr_count <= '0;
    end else begin
      state <= state_next;
      if (state == T5)
        instr_count <= instr_count + COUNT_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = run ? T0 : IDLE;
      T0:      state_next = T1;
      T1:      state_next = mem_ready ? T2 : T1;
      T2:      state_next = DEC;
      DEC: begin
        if (op <= ALU_OP_MAX)
          state_next = T3;
        else if (op == HALT_OP)
          state_next = HALTED;
        else
          state_next = ERROR;
      end
      T3:      state_next = T4;
      T4:      state_next = T5;
      T5:      state_next = run ? T0 : IDLE;
      HALTED:  state_next = HALTED;
      ERROR:   state_next = ERROR;
      default: state_next = IDLE;
    endcase
  end

  // Moore decode: every output is a function of the state register alone,
  // apart from the IR fields steering the GPR selects and ALU op.
  always_comb begin
    pc_out       = 1'b0;
    mdr_out      = 1'b0;
    zlo_out      = 1'b0;
    mar_enable   = 1'b0;
    pc_enable    = 1'b0;
    pc_increment = 1'b0;
    read         = 1'b0;
    mdr_enable   = 1'b0;
    ir_enable    = 1'b0;
    y_enable     = 1'b0;
    z_enable     = 1'b0;
    r_out        = '0;
    r_enable     = '0;
    op_code      = '0;
    halted       = 1'b0;
    error        = 1'b0;
    case (state)
      T0: begin
        pc_out       = 1'b1;
        mar_enable   = 1'b1;
        pc_increment = 1'b1;
        pc_enable    = 1'b1;
      end
      T1: begin
        read       = 1'b1;
        mdr_enable = 1'b1;
      end
      T2: begin
        mdr_out   = 1'b1;
        ir_enable = 1'b1;
      end
      T3: begin
        r_out[rb] = 1'b1;
        y_enable  = 1'b1;
      end
      T4: begin
        r_out[rc] = 1'b1;
        op_code   = op;
        z_enable  = 1'b1;
      end
      T5: begin
        zlo_out      = 1'b1;
        r_enable[ra] = 1'b1;
      end
      HALTED:  halted = 1'b1;
      ERROR:   error  = 1'b1;
      default: ;
    endcase
  end

  assign busy = (state != IDLE) && (state != HALTED) && (state != ERROR);

endmodule

// File: tb/tb_control_sequencer.sv
// Directed, table-driven bench for control_sequencer: per-cycle input records
// with hand-computed expected outputs, plus a HALT hold sequence.
module tb_control_sequencer;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_DEC, S_T3, S_T4, S_T5, S_HALTED, S_ERROR
  } st_e;

  typedef struct packed {
    logic pc_out, mdr_out, zlo_out, mar_enable, pc_enable, pc_increment;
    logic read, mdr_enable, ir_enable, y_enable, z_enable;
    logic busy, halted, error;
  } ctl_t;

  typedef struct {
    logic        clr, run, mem_ready;
    logic [31:0] ir;
    st_e         st;
    logic [15:0] rout, ren;
    logic [4:0]  op;
    logic [15:0] cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        run = 1'b0;
  logic        mem_ready = 1'b1;
  logic [31:0] ir_data = '0;
  logic        pc_out, mdr_out, zlo_out, mar_enable, pc_enable, pc_increment;
  logic        read, mdr_enable, ir_enable, y_enable, z_enable;
  logic [15:0] r_out, r_enable;
  logic [4:0]  op_code;
  logic        busy, halted, error;
  logic [15:0] instr_count;

  int   errors = 0;
  int   checks = 0;
  vec_t vecs[$];

  // op, Ra, Rb, Rc
  localparam logic [31:0] I_A   = {5'd3,  4'd1,  4'd2, 4'd3, 15'd0};
  localparam logic [31:0] I_B   = {5'd11, 4'd15, 4'd0, 4'd0, 15'd0};
  localparam logic [31:0] I_C   = {5'd0,  4'd2,  4'd2, 4'd5, 15'd0};
  localparam logic [31:0] I_H   = {5'd27, 27'd0};
  localparam logic [31:0] I_E20 = {5'd20, 4'd1,  4'd2, 4'd3, 15'd0};
  localparam logic [31:0] I_E12 = {5'd12, 4'd4,  4'd5, 4'd6, 15'd0};

  control_sequencer #(
    .ALU_OP_MAX(5'd11),
    .HALT_OP   (5'b11011),
    .COUNT_W   (16)
  ) dut (
    .clk         (clk),
    .clr         (clr),
    .run         (run),
    .mem_ready   (mem_ready),
    .ir_data     (ir_data),
    .pc_out      (pc_out),
    .mdr_out     (mdr_out),
    .zlo_out     (zlo_out),
    .mar_enable  (mar_enable),
    .pc_enable   (pc_enable),
    .pc_increment(pc_increment),
    .read        (read),
    .mdr_enable  (mdr_enable),
    .ir_enable   (ir_enable),
    .y_enable    (y_enable),
    .z_enable    (z_enable),
    .r_out       (r_out),
    .r_enable    (r_enable),
    .op_code     (op_code),
    .busy        (busy),
    .halted      (halted),
    .error       (error),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  function automatic ctl_t ctl_of(st_e s);
    ctl_t c = '0;
    case (s)
      S_T0:     begin c.pc_out = 1; c.mar_enable = 1; c.pc_enable = 1; c.pc_increment = 1; end
      S_T1:     begin c.read = 1; c.mdr_enable = 1; end
      S_T2:     begin c.mdr_out = 1; c.ir_enable = 1; end
      S_T3:     c.y_enable = 1;
      S_T4:     c.z_enable = 1;
      S_T5:     c.zlo_out = 1;
      S_HALTED: c.halted = 1;
      S_ERROR:  c.error = 1;
      default:  ;
    endcase
    c.busy = !(s inside {S_IDLE, S_HALTED, S_ERROR});
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic c, input logic r, input logic m, input logic [31:0] ir,
                     input st_e s, input logic [15:0] ro, input logic [15:0] re,
                     input logic [4:0] op, input logic [15:0] cnt);
    vec_t v;
    v.clr = c; v.run = r; v.mem_ready = m; v.ir = ir; v.st = s;
    v.rout = ro; v.ren = re; v.op = op; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  // One ALU instruction entered with run=1; keep is run seen while in T4.
  task automatic add_alu(input logic [31:0] ir, input logic [15:0] cnt,
                         input logic [15:0] r3, input logic [15:0] r4,
                         input logic [4:0] op4, input logic [15:0] r5, input logic keep);
    add(1, 1, 1, ir, S_T0,  '0, '0, '0,  cnt);
    add(1, 1, 1, ir, S_T1,  '0, '0, '0,  cnt);
    add(1, 1, 1, ir, S_T2,  '0, '0, '0,  cnt);
    add(1, 1, 1, ir, S_DEC, '0, '0, '0,  cnt);
    add(1, 1, 1, ir, S_T3,  r3, '0, '0,  cnt);
    add(1, 1, 1, ir, S_T4,  r4, '0, op4, cnt);
    add(1, keep, 1, ir, S_T5, '0, r5, '0, cnt);
  endtask

  task automatic fetch_to_dec(input logic [31:0] ir, input logic [15:0] cnt);
    add(1, 1, 1, ir, S_T0,  '0, '0, '0, cnt);
    add(1, 1, 1, ir, S_T1,  '0, '0, '0, cnt);
    add(1, 1, 1, ir, S_T2,  '0, '0, '0, cnt);
    add(1, 1, 1, ir, S_DEC, '0, '0, '0, cnt);
  endtask

  task automatic sample(input string tag);
    ctl_t act;
    int   drivers;
    act = {pc_out, mdr_out, zlo_out, mar_enable, pc_enable, pc_increment,
           read, mdr_enable, ir_enable, y_enable, z_enable, busy, halted, error};
    drivers = int'(pc_out) + int'(mdr_out) + int'(zlo_out) + int'(r_out != '0);
    check({tag, " bus_drivers<=1"}, 32'(drivers <= 1), 32'd1);
    if (tag.len() == 0) ;
  endtask

  initial begin
    // reset with run high, then single add
    add(0, 1, 1, I_A, S_IDLE, '0, '0, '0, 16'd0);
    add(0, 1, 1, I_A, S_IDLE, '0, '0, '0, 16'd0);
    add_alu(I_A, 16'd0, 16'h0004, 16'h0008, 5'd3, 16'h0002, 1'b0);
    add(1, 0, 1, I_A, S_IDLE, '0, '0, '0, 16'd1);
    // memory wait: three mem_ready=0 cycles in T1, boundary opcode, Rb==Rc
    add(1, 1, 0, I_B, S_T0,  '0, '0, '0, 16'd1);
    add(1, 0, 0, I_B, S_T1,  '0, '0, '0, 16'd1);
    add(1, 0, 0, I_B, S_T1,  '0, '0, '0, 16'd1);
    add(1, 0, 0, I_B, S_T1,  '0, '0, '0, 16'd1);
    add(1, 0, 0, I_B, S_T1,  '0, '0, '0, 16'd1);
    add(1, 0, 1, I_B, S_T2,  '0, '0, '0, 16'd1);
    add(1, 0, 1, I_B, S_DEC, '0, '0, '0, 16'd1);
    add(1, 0, 1, I_B, S_T3,  16'h0001, '0, '0, 16'd1);
    add(1, 0, 1, I_B, S_T4,  16'h0001, '0, 5'd11, 16'd1);
    add(1, 0, 1, I_B, S_T5,  '0, 16'h8000, '0, 16'd1);
    add(1, 0, 1, I_B, S_IDLE, '0, '0, '0, 16'd2);
    // illegal opcodes: 20 and first value past ALU_OP_MAX
    add(0, 0, 1, I_E20, S_IDLE, '0, '0, '0, 16'd0);
    fetch_to_dec(I_E20, 16'd0);
    add(1, 1, 1, I_E20, S_ERROR, '0, '0, '0, 16'd0);
    add(1, 1, 1, I_E20, S_ERROR, '0, '0, '0, 16'd0);
    add(0, 0, 1, I_E12, S_IDLE, '0, '0, '0, 16'd0);
    fetch_to_dec(I_E12, 16'd0);
    add(1, 1, 1, I_E12, S_ERROR, '0, '0, '0, 16'd0);
    // reset in T4 of the second instruction, Ra==Rb
    add(0, 0, 1, I_A, S_IDLE, '0, '0, '0, 16'd0);
    add_alu(I_A, 16'd0, 16'h0004, 16'h0008, 5'd3, 16'h0002, 1'b1);
    add(1, 1, 1, I_C, S_T0,  '0, '0, '0, 16'd1);
    add(1, 1, 1, I_C, S_T1,  '0, '0, '0, 16'd1);
    add(1, 1, 1, I_C, S_T2,  '0, '0, '0, 16'd1);
    add(1, 1, 1, I_C, S_DEC, '0, '0, '0, 16'd1);
    add(1, 1, 1, I_C, S_T3,  16'h0004, '0, '0, 16'd1);
    add(1, 1, 1, I_C, S_T4,  16'h0020, '0, 5'd0, 16'd1);
    add(0, 1, 1, I_C, S_IDLE, '0, '0, '0, 16'd0);
    add(1, 0, 1, I_C, S_IDLE, '0, '0, '0, 16'd0);
    // back-to-back, run dropped while the third is in T4
    add_alu(I_A, 16'd0, 16'h0004, 16'h0008, 5'd3, 16'h0002, 1'b1);
    add_alu(I_C, 16'd1, 16'h0004, 16'h0020, 5'd0, 16'h0004, 1'b1);
    add_alu(I_B, 16'd2, 16'h0001, 16'h0001, 5'd11, 16'h8000, 1'b0);
    add(1, 0, 1, I_B, S_IDLE, '0, '0, '0, 16'd3);
    // HALT leaves the count alone
    fetch_to_dec(I_H, 16'd3);
    add(1, 1, 1, I_H, S_HALTED, '0, '0, '0, 16'd3);

    foreach (vecs[k]) begin
      clr       = vecs[k].clr;
      run       = vecs[k].run;
      mem_ready = vecs[k].mem_ready;
      ir_data   = vecs[k].ir;
      @(posedge clk);
      #1;
      check($sformatf("v%0d ctl", k), 32'({pc_out, mdr_out, zlo_out, mar_enable, pc_enable,
            pc_increment, read, mdr_enable, ir_enable, y_enable, z_enable, busy, halted, error}),
            32'(ctl_of(vecs[k].st)));
      check($sformatf("v%0d r_out", k),       32'(r_out),       32'(vecs[k].rout));
      check($sformatf("v%0d r_enable", k),    32'(r_enable),    32'(vecs[k].ren));
      check($sformatf("v%0d op_code", k),     32'(op_code),     32'(vecs[k].op));
      check($sformatf("v%0d instr_count", k), 32'(instr_count), 32'(vecs[k].cnt));
      sample($sformatf("v%0d", k));
    end

    // HALTED must hold for 20 cycles with run high
    for (int i = 0; i < 20; i++) begin
      run       = 1'b1;
      mem_ready = 1'b1;
      @(posedge clk);
      #1;
      check($sformatf("hold%0d halted/busy/error", i), 32'({halted, busy, error}), 32'b100);
      check($sformatf("hold%0d count/ren", i), 32'({instr_count, r_enable}), {16'd3, 16'h0000});
    end

    clr = 1'b0;
    @(posedge clk);
    #1;
    check("final reset halted", 32'(halted), 32'd0);
    check("final reset count",  32'(instr_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Hardwired control unit that drives the single-bus datapath's control inputs. It steps each instruction through fetch (T0–T2) and register-register ALU execute (T3–T5), decoding register fields and opcode from the IR contents. It handles a memory-ready handshake during fetch, a HALT opcode and illegal-opcode detection. It sits between the top-level run/memory interface and the datapath's enable, out-select, read and op_code inputs.

Parameters:
ALU_OP_MAX, 5'd11, highest opcode treated as a 3-register ALU op; opcodes 0..ALU_OP_MAX are legal ALU ops.
HALT_OP, 5'b11011, opcode that stops sequencing.
COUNT_W, 16, width of the retired-instruction counter.

Ports:
clk  input  1  rising-edge clock
clr  input  1  reset; synchronous, active-low
run  input  1  level; start/continue sequencing
mem_ready  input  1  memory data valid on m_data_in
ir_data  input  32  IR contents; op=[31:27], Ra=[26:23], Rb=[22:19], Rc=[18:15]
pc_out  output  1  PC drives bus
mdr_out  output  1  MDR drives bus
zlo_out  output  1  Z low drives bus
mar_enable  output  1  load MAR
pc_enable  output  1  load PC
pc_increment  output  1  PC increment
read  output  1  MDR mux selects memory
mdr_enable  output  1  load MDR
ir_enable  output  1  load IR
y_enable  output  1  load Y
z_enable  output  1  load Z
r_out  output  16  one-hot GPR bus drive, bit n = Rn
r_enable  output  16  one-hot GPR load, bit n = Rn
op_code  output  5  ALU operation
busy  output  1  high in any state except IDLE, HALTED, ERROR
halted  output  1  high in HALTED
error  output  1  high in ERROR
instr_count  output  COUNT_W  retired ALU instructions

Behaviour:
- All state and instr_count update on rising clk. When clr=0 at an edge: state goes to IDLE and instr_count goes to 0, regardless of current state, including mid-instruction.
- Control outputs are Moore-decoded from the state register. In IDLE and after reset, every output is 0.
- States and transitions:
  - IDLE: go to T0 if run=1.
  - T0: assert pc_out, mar_enable, pc_increment, pc_enable. Go to T1.
  - T1: assert read, mdr_enable. Stay in T1 while mem_ready=0; go to T2 when mem_ready=1. The MDR reloads every cycle in T1, so the last load captures valid data.
  - T2: assert mdr_out, ir_enable. Go to DEC.
  - DEC: no outputs asserted; the IR is now valid. Decode the opcode:
    - op <= ALU_OP_MAX → T3
    - op == HALT_OP → HALTED
    - any other op → ERROR
  - T3: r_out[Rb]=1, y_enable. Go to T4.
  - T4: r_out[Rc]=1, op_code=ir_data[31:27], z_enable. Go to T5.
  - T5: zlo_out, r_enable[Ra]=1. Increment instr_count. Go to T0 if run=1, else IDLE.
  - HALTED: halted=1. Leave only via reset.
  - ERROR: error=1. Leave only via reset.
- op_code is 0 in every state except T4.
- r_out and r_enable are exactly one-hot in T3/T4/T5 and all-zero elsewhere.
- At most one bus driver (pc_out, mdr_out, zlo_out, r_out) is asserted per cycle.
- Register fields:
  - Rb==Rc is legal; the same register drives both.
  - Ra equal to Rb or Rc is legal; the write happens at the T5 edge, after the reads.
- Latency: 7 cycles per ALU instruction (T0..T5 plus DEC) with mem_ready tied high; each mem_ready=0 cycle in T1 adds one cycle.
- If run drops mid-instruction, the current instruction completes through T5, then the block enters IDLE. run is sampled only in IDLE and T5.
- instr_count wraps from all-ones to 0. It does not count HALT or illegal instructions.
- ir_data is sampled combinationally in DEC, T3, T4 and T5. It must remain stable from T2 onward; IR is loaded only in T2.

Test Plan:
- Reset: clr=0 for 2 cycles while run=1 → all outputs 0, instr_count=0. Release with run=1 → T0 on the next cycle: pc_out=1, mar_enable=1.
- Single add, mem_ready=1, ir_data={5'd3,4'd1,4'd2,4'd3,15'd0}:
  - r_out=16'h0004 with y_enable in T3
  - r_out=16'h0008, op_code=5'd3, z_enable in T4
  - r_enable=16'h0002, zlo_out in T5
  - instr_count=1, 7 cycles total from T0
- Memory wait: mem_ready=0 for 3 cycles in T1 → read and mdr_enable held for 4 cycles; T2 entered on the cycle after mem_ready=1; total 10 cycles.
- Back-to-back: run held high, 3 ALU instructions → T0 follows T5 directly, instr_count=3. Then drop run during the 3rd instruction's T4 → IDLE after T5, busy=0.
- HALT/illegal:
  - ir op=5'b11011 → halted=1 after DEC; stays high with run=1 for 20 cycles; instr_count unchanged.
  - After reset, op=5'd20 → error=1, no r_enable pulse.
- Reset mid-op: clr=0 asserted in T4 → next cycle IDLE, z_enable=0, instr_count=0, no r_enable pulse.
